// File: rtl/div_sched.sv
// div_sched: multi-cycle restoring divider for DIV/DIVU, one quotient bit per cycle.
// Optional macro DIV_FAST_BYZERO_EN short-circuits a zero divisor through BYZERO.
module div_sched #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);
  localparam logic [1:0] FREE = 2'd0;
`ifdef DIV_FAST_BYZERO_EN
  localparam logic [1:0] BYZERO = 2'd1;
`endif
  localparam logic [1:0] ON = 2'd2;
  localparam logic [1:0] END = 2'd3;
  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W:0]   dividend_q, dividend_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic [DATA_W:0]     t;
  logic [DATA_W-1:0]   mag1, mag2, quo, rem;
  // dividend_q layout: [2W:W+1] partial remainder, [W:1] pending dividend bits / quotient, [0] newest quotient bit
  always_comb begin
    t = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    quo = qneg_q ? -dividend_q[DATA_W-1:0] : dividend_q[DATA_W-1:0];
    rem = rneg_q ? -dividend_q[2*DATA_W:DATA_W+1] : dividend_q[2*DATA_W:DATA_W+1];
    state_d = state_q;
    cnt_d = cnt_q;
    dividend_d = dividend_q;
    divisor_d = divisor_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    result_d = result_q;
    ready_d = ready_q;
    case (state_q)
      FREE: begin
        result_d = '0;
        ready_d = 1'b0;
        cnt_d = '0;
        if (start_i && !annul_i) begin
          state_d = ON;
          dividend_d = {{DATA_W{1'b0}}, mag1, 1'b0};
          divisor_d = mag2;
          qneg_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          rneg_d = signed_div_i && opdata1_i[DATA_W-1];
`ifdef DIV_FAST_BYZERO_EN
          if (opdata2_i == '0) state_d = BYZERO;
`endif
        end
      end
`ifdef DIV_FAST_BYZERO_EN
      BYZERO: begin
        state_d = END;
        result_d = '0;
      end
`endif
      ON: begin
        if (annul_i) begin
          state_d = FREE;
          cnt_d = '0;
          ready_d = 1'b0;
        end else if (cnt_q != LAST) begin
          dividend_d = t[DATA_W] ? {dividend_q[2*DATA_W-1:0], 1'b0}
                                 : {t[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = END;
          cnt_d = '0;
          result_d = {rem, quo};
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = start_i ? END : FREE;
        result_d = start_i ? result_q : '0;
        ready_d = start_i;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FREE;
      cnt_q <= '0;
      dividend_q <= '0;
      divisor_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      result_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q <= divisor_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      result_q <= result_d;
      ready_q <= ready_d;
    end
  end
  assign result_o = result_q;
  assign ready_o = ready_q;
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: randomized divide traffic checked every cycle against a transaction-level model.
module tb_div_sched;
  localparam int W = 32;
`ifdef DIV_FAST_BYZERO_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, signed_div = 1'b0, start = 1'b0, annul = 1'b0;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic [2*W-1:0] result;
  logic ready;
  int checks = 0, errors = 0;
  logic armed = 1'b0;
  div_sched #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma, mb, q, r;
    ma = (s && a[W-1]) ? -a : a;
    mb = (s && b[W-1]) ? -b : b;
    if (mb == 0) begin
      q = '1;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (s && (a[W-1] ^ b[W-1])) q = -q;
    if (s && a[W-1]) r = -r;
    return {r, q};
  endfunction
  // Model: idle -> busy for a fixed number of edges -> done (held while start stays high)
  logic m_busy = 0, m_done = 0, m_ready = 0, m_fast = 0;
  logic [63:0] m_res = '0, m_out = '0;
  int m_left = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_ready <= 0; m_out <= '0;
    end else if (m_done) begin
      if (!start) begin m_done <= 0; m_ready <= 0; m_out <= '0; end
    end else if (m_busy) begin
      if (annul && !m_fast) m_busy <= 0;
      else if (m_left == 1) begin
        m_busy <= 0;
        if (!(m_fast && !start)) begin m_done <= 1; m_ready <= 1; m_out <= m_res; end
      end else m_left <= m_left - 1;
    end else if (start && !annul) begin
      m_busy <= 1;
      m_fast <= FAST && op2 == '0;
      m_left <= (FAST && op2 == '0) ? 2 : 33;
      m_res <= (FAST && op2 == '0) ? '0 : ref_div(signed_div, op1, op2);
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("ready", {63'd0, ready}, {63'd0, m_ready});
      chk("result", result, m_out);
    end
  end
  task automatic run(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                     output int n, output logic [63:0] res);
    signed_div = s; op1 = a; op2 = b; start = 1; annul = 0;
    n = -1;
    do begin
      @(posedge clk); #1; n++;
      if (n == 0) begin op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom); end
    end while (!ready && n < 40);
    res = result;
    if (!ready) chk("ready_timeout", 64'd0, 64'd1);
    repeat (hold) begin @(posedge clk); #1; end
    start = 0;
    @(posedge clk); #1;
  endtask
  task automatic abort(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    signed_div = s; op1 = a; op2 = b; start = 1; annul = 0;
    repeat (k + 1) begin @(posedge clk); #1; end
    annul = 1; start = 0;
    @(posedge clk); #1;
    annul = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic [63:0] res;
    logic s;
    logic [W-1:0] a, b;
    @(posedge clk); #1;
    armed = 1;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    chk("pin_divu", ref_div(0, 32'hFFFFFFFF, 32'h10), 64'h0000000F_0FFFFFFF);
    chk("pin_div", ref_div(1, 32'hFFFFFFF9, 32'h2), 64'hFFFFFFFF_FFFFFFFD);
    chk("pin_ovf", ref_div(1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    chk("pin_zero", ref_div(0, 32'h12345678, 32'h0), 64'h12345678_FFFFFFFF);
    run(0, 32'hFFFFFFFF, 32'h10, 2, n, res);
    chk("divu_lat", 64'(n), 64'd33);
    chk("divu_res", res, 64'h0000000F_0FFFFFFF);
    run(1, 32'hFFFFFFF9, 32'h2, 0, n, res);
    chk("div_lat", 64'(n), 64'd33);
    chk("div_res", res, 64'hFFFFFFFF_FFFFFFFD);
    chk("drop_ready", {63'd0, ready}, 64'd0);
    chk("drop_result", result, 64'd0);
    run(1, 32'h80000000, 32'hFFFFFFFF, 1, n, res);
    chk("ovf_lat", 64'(n), 64'd33);
    chk("ovf_res", res, 64'h00000000_80000000);
    run(0, 32'h12345678, 32'h0, 1, n, res);
`ifdef DIV_FAST_BYZERO_EN
    chk("zero_lat", 64'(n), 64'd2);
    chk("zero_res", res, 64'd0);
`else
    chk("zero_lat", 64'(n), 64'd33);
    chk("zero_res", res, 64'h12345678_FFFFFFFF);
`endif
    abort(0, 32'd100, 32'd3, 10);
    chk("annul_ready", {63'd0, ready}, 64'd0);
    repeat (30) begin @(posedge clk); #1; end
    chk("annul_idle", {63'd0, ready}, 64'd0);
    run(0, 32'd100, 32'd3, 0, n, res);
    chk("restart_lat", 64'(n), 64'd33);
    chk("restart_res", res, {32'd1, 32'd33});
    signed_div = 0; op1 = 32'd1000; op2 = 32'd7; start = 1;
    repeat (20) begin @(posedge clk); #1; end
    rst = 1; start = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_result", result, 64'd0);
    repeat (40) begin @(posedge clk); #1; end
    run(1, 32'd1000, 32'hFFFFFFF9, 0, n, res);
    chk("post_rst_lat", 64'(n), 64'd33);
    chk("post_rst_res", res, {32'd6, 32'hFFFFFF72});
    for (int i = 0; i < 200; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 50);
        4: b = -$urandom_range(1, 9);
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) abort(s, a, b, $urandom_range(0, 36));
      else run(s, a, b, $urandom_range(0, 3), n, res);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Multi-cycle 32-bit integer divide sequencer that sits beside the EX stage and serves DIV/DIVU.
- The EX stage raises start_i with both operands and holds its own stall request until ready_o is high.
- The block runs a restoring divide at one quotient bit per cycle, then presents {remainder, quotient} for the HI/LO write path.
- annul_i cancels an in-flight divide when the pipeline flushes.

Parameters:
- DATA_W, 32, operand width. The iteration count equals DATA_W and result width is 2*DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high (RstEnable = 1)
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  DATA_W  dividend
- opdata2_i  input  DATA_W  divisor
- start_i  input  1  divide request, level, held by EX while stalled
- annul_i  input  1  cancel current operation (flush)
- result_o  output  2*DATA_W  [2W-1:W] = remainder (HI), [W-1:0] = quotient (LO)
- ready_o  output  1  result valid

Behaviour:
- Reset: at a clk edge with rst=1, the FSM goes to FREE, cnt=0, result_o=0, ready_o=0. Reset wins over every other input in any state, including mid-divide.
- Registers:
  - state: FREE, BYZERO, ON, END
  - cnt: 6 bits, 0..32
  - dividend: 2W+1 bits, working register
  - divisor: W bits
- Edge numbering: E0 is the edge that samples start_i=1; E0+n is the nth edge after it.
- FREE:
  - If start_i=1 and annul_i=0 and divisor=0: go to BYZERO.
  - If start_i=1 and annul_i=0 and divisor≠0: go to ON with cnt=0.
    - Operands are captured as magnitudes when signed_div_i=1 and the operand is negative (two's complement), otherwise as-is.
    - dividend is loaded with {W'b0, |op1|, 1'b0}.
  - Otherwise stay in FREE. ready_o=0 and result_o=0.
- BYZERO: go to END with result 0. ready_o=1 after E0+2.
- ON, cnt<32, annul_i=0: one iteration per edge.
  - t = {1'b0, dividend[2W-1:W]} − {1'b0, divisor}.
  - If t[W]=1 (negative): dividend <= dividend << 1.
  - Else: dividend <= {t[W-1:0], dividend[W-1:0], 1'b1}.
  - cnt <= cnt+1.
- ON, cnt=32: apply sign fixups, latch result_o, go to END with ready_o=1.
  - Quotient is negated when signed and the operand signs differ.
  - Remainder is negated when signed and the dividend is negative.
  - ready_o=1 after E0+33, giving 33 stall cycles seen by EX.
- ON with annul_i=1: next edge goes to FREE, cnt=0, ready_o=0. No result is produced.
- END:
  - Hold result_o and ready_o=1 while start_i=1.
  - When start_i=0, next edge goes to FREE with ready_o=0 and result_o=0.
  - annul_i in END is ignored; result_o is only cleared when start_i drops.
- Operands are sampled only in FREE. Input changes during ON or END have no effect.
- Signed overflow 0x80000000 / −1: quotient 0x80000000, remainder 0, no trap.
- Widths: magnitude of 0x80000000 is 0x80000000 as unsigned, and the fixup wraps modulo 2^W.

Optional Feature:
- Macro: DIV_FAST_BYZERO_EN.
- Defined: a zero divisor takes the BYZERO path; result_o=0 and ready_o high after E0+2.
- Undefined: the BYZERO state is not compiled. A zero divisor runs the normal 32 iterations, giving quotient all-ones and remainder = |dividend|, with sign fixups applied when signed. ready_o is high after E0+33.

Test Plan:
- Unsigned divide: DIVU 0xFFFFFFFF / 0x00000010 with start held → ready_o=1 after E0+33; result_o = {0x0000000F, 0x0FFFFFFF}.
- Signed divide: DIV 0xFFFFFFF9 (−7) / 2 → result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Deassert start_i → next edge ready_o=0, result_o=0.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → result_o = {0x00000000, 0x80000000}, ready_o after E0+33.
- Divide by zero: DIVU 0x12345678 / 0.
  - With DIV_FAST_BYZERO_EN: ready_o after E0+2, result_o=0.
  - Without it: ready_o after E0+33, result_o = {0x12345678, 0xFFFFFFFF}.
- Annul: start DIVU 100/3, assert annul_i for one cycle at E0+10 → FSM in FREE at E0+11, ready_o stays 0. Then restart with start_i (annul_i=0) → result {1, 33} after 33 further edges.
- Reset mid-operation: rst=1 at E0+20 → next edge result_o=0, ready_o=0, state FREE. A fresh start then completes normally.
